ines_loader: RTL
================

INES_LOADER -- requirements
Module: ines_loader

Interface
REQ-001 Parameter PRG_BASE, default 22'h000000, SDRAM byte address of first PRG byte.
REQ-002 Parameter CHR_BASE, default 22'h200000, SDRAM byte address of first CHR byte.
REQ-003 Parameter FIFO_DEPTH, default 4, byte buffer depth; power of two, minimum 2.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 rom_loading  in  1  level from iosys; 0->1 starts a load, 1->0 ends it.
REQ-007 rom_do  in  8  ROM byte from iosys, stable while rom_do_valid is high.
REQ-008 rom_do_valid  in  1  byte strobe; may stay high several cycles; each 0->1 edge is one byte.
REQ-009 mem_addr  out  22  SDRAM byte write address.
REQ-010 mem_din  out  8  SDRAM write data.
REQ-011 mem_we  out  1  write request; held with addr/data stable until mem_ack.
REQ-012 mem_ack  in  1  one-cycle write-complete pulse from the SDRAM arbiter.
REQ-013 prg_size, chr_size  out  8 each  header bytes 4 and 5 (16KB and 8KB units).
REQ-014 mapper  out  8  {flags7[7:4], flags6[7:4]}.
REQ-015 mirroring  out  1  flags6[0].
REQ-016 busy, loader_done, loader_error  out  1 each  status flags.

Function
REQ-017 FSM states: IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR.
REQ-018 A 0->1 edge on rom_loading in any state shall enter HEADER next cycle, clearing byte counter, FIFO, loader_done and loader_error.
REQ-019 Byte capture: a byte is taken on the cycle after a rom_do_valid 0->1 edge is registered; ignored in IDLE, DONE and ERROR.
REQ-020 HEADER consumes 16 bytes without memory writes; bytes 0-3 must equal 4E 45 53 1A, else ERROR right after the mismatching byte.
REQ-021 Bytes 4, 5, 6, 7 are latched into prg_size, chr_size, flags6, flags7; bytes 8-15 are discarded.
REQ-022 After byte 15: TRAINER if flags6[2]=1; else PRG if prg_size!=0; else ERROR.
REQ-023 TRAINER discards exactly 512 bytes, then enters PRG.
REQ-024 PRG queues prg_size*16384 bytes into the FIFO, addresses PRG_BASE+offset.
REQ-025 After the last PRG byte: CHR if chr_size!=0, else DONE once the FIFO drains and the last ack arrives.
REQ-026 CHR queues chr_size*8192 bytes, addresses CHR_BASE+offset; DONE when drained.
REQ-027 Offset counter is 22 bits wide; base+offset wraps modulo 2^22.
REQ-028 FIFO entries are {addr,data}; the head is presented on mem_addr/mem_din with mem_we=1 while non-empty.
REQ-029 The FIFO pops on the cycle mem_ack=1; the next entry appears the following cycle, so there is 1 cycle minimum between requests.
REQ-030 A capture and a pop in the same cycle shall both occur, leaving occupancy unchanged.
REQ-031 A capture into a full FIFO with no pop that cycle shall enter ERROR and drop the byte.
REQ-032 Bytes arriving in DONE (file padding) are ignored; loader_done stays 1.
REQ-033 A 1->0 edge on rom_loading in HEADER, TRAINER, PRG or CHR shall enter ERROR.
REQ-034 Entering ERROR flushes the FIFO and deasserts mem_we next cycle; an in-flight request is abandoned and a late mem_ack is ignored.
REQ-035 busy=1 in HEADER, TRAINER, PRG, CHR, or while the FIFO is non-empty.
REQ-036 loader_done=1 only in DONE; loader_error=1 only in ERROR; both sticky until the next start edge.

Reset
REQ-037 resetn=0 shall immediately force IDLE, empty the FIFO, and set every output to 0 (mem_we, busy, loader_done, loader_error, sizes, mapper, mirroring, mem_addr, mem_din).
REQ-038 Reset mid-load shall abandon the load; no mem_we shall assert until a new start edge and a full header.
REQ-039 The edge-detect registers for rom_loading and rom_do_valid reset to 0, so a level held high across reset release counts as an edge.

Verification
REQ-040 Header 4E 45 53 1A 02 01 01 00 + 32768 PRG + 8192 CHR, mem_ack 2 cycles after each mem_we -> prg_size=2, chr_size=1, mirroring=1, mapper=0; last PRG write at addr 0x007FFF; last CHR write at 0x201FFF; loader_done=1.
REQ-041 First byte 4E, second byte 00 -> ERROR after byte 1; loader_error=1; no mem_we ever asserted.
REQ-042 flags6=0x14, flags7=0x40, chr_size=0 -> 512 trainer bytes skipped; first PRG write is the 529th byte at addr 0; mapper=0x41; DONE after PRG without CHR writes.
REQ-043 mem_ack withheld 40 cycles while bytes arrive every 4 cycles -> FIFO overflows on the 5th queued byte; ERROR; mem_we=0 the next cycle.
REQ-044 rom_loading drops after 100 PRG bytes -> loader_error=1; then a new 0->1 start edge with a valid file -> flags cleared and a full successful load.
REQ-045 resetn asserted mid-PRG with mem_we=1 -> all outputs 0 immediately without waiting for a clock edge; state IDLE.

Source files
------------

// File: rtl/ines_loader.sv
// ---------------------------------------------------------------------------
// ines_loader
//
// Streams an iNES ROM image, delivered one byte at a time by iosys, into
// SDRAM. The 16-byte header is parsed and checked. An optional 512-byte
// trainer is skipped. The PRG image is then written from PRG_BASE and the
// CHR image from CHR_BASE. Bytes pass through a small {addr,data} FIFO so
// that SDRAM arbitration latency does not stall the byte stream.
//
// Ports
//   clk           : single clock; all state changes on its rising edge
//   resetn        : asynchronous active-low reset
//   rom_loading   : load window level from iosys (0->1 start, 1->0 end)
//   rom_do        : ROM byte, stable while rom_do_valid is high
//   rom_do_valid  : byte strobe; each 0->1 edge delivers one byte
//   mem_addr      : SDRAM byte write address (FIFO head)
//   mem_din       : SDRAM write data (FIFO head)
//   mem_we        : write request, held until mem_ack
//   mem_ack       : one-cycle write-complete pulse
//   prg_size      : header byte 4 (16 KB units)
//   chr_size      : header byte 5 (8 KB units)
//   mapper        : {flags7[7:4], flags6[7:4]}
//   mirroring     : flags6[0]
//   busy          : load in progress or writes still pending
//   loader_done   : image fully written (sticky until next start)
//   loader_error  : load failed (sticky until next start)
// ---------------------------------------------------------------------------
module ines_loader #(
  parameter logic [21:0] PRG_BASE   = 22'h000000,
  parameter logic [21:0] CHR_BASE   = 22'h200000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [7:0]  prg_size,
  output logic [7:0]  chr_size,
  output logic [7:0]  mapper,
  output logic        mirroring,
  output logic        busy,
  output logic        loader_done,
  output logic        loader_error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_TRAINER,
    S_PRG,
    S_CHR,
    S_DONE,
    S_ERROR
  } state_t;

  // Expected magic "NES\x1A" for header bytes 0..3.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'h4E;
      2'd1:    magic_byte = 8'h45;
      2'd2:    magic_byte = 8'h53;
      default: magic_byte = 8'h1A;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [21:0]        cnt_q, cnt_d;        // byte index within current section
  logic               tail_q, tail_d;      // all section bytes queued, draining
  logic [7:0]         prg_size_q, prg_size_d;
  logic [7:0]         chr_size_q, chr_size_d;
  logic [7:0]         mapper_q, mapper_d;
  logic               trainer_q, trainer_d;
  logic               mirroring_q, mirroring_d;

  logic               loading_q;           // previous rom_loading
  logic               valid_q;             // previous rom_do_valid
  logic               stb_q;               // registered rom_do_valid rising edge
  logic [7:0]         byte_q;              // byte captured at that edge

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [21:0]        fifo_addr_q [FIFO_DEPTH];
  logic [7:0]         fifo_data_q [FIFO_DEPTH];

  // ------------------------------------------------------------------
  // Combinational control
  // ------------------------------------------------------------------
  logic        start, stop, valid_rise, active, cap;
  logic        fifo_empty, fifo_full, pop, push, flush;
  logic [21:0] push_addr, cnt_inc, sec_base, sec_len;

  assign start      = rom_loading & ~loading_q;
  assign stop       = ~rom_loading & loading_q;
  assign valid_rise = rom_do_valid & ~valid_q;

  assign active = (state_q == S_HEADER) || (state_q == S_TRAINER) ||
                  (state_q == S_PRG)    || (state_q == S_CHR);

  // Once a section's last byte is queued, further bytes are padding.
  assign cap = stb_q & active & ~tail_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = mem_ack & ~fifo_empty;

  assign cnt_inc  = cnt_q + 22'd1;
  assign sec_base = (state_q == S_CHR) ? CHR_BASE : PRG_BASE;
  assign sec_len  = (state_q == S_CHR) ? {1'b0, chr_size_q, 13'd0}
                                       : {prg_size_q, 14'd0};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    prg_size_d  = prg_size_q;
    chr_size_d  = chr_size_q;
    mapper_d    = mapper_q;
    trainer_d   = trainer_q;
    mirroring_d = mirroring_q;
    push        = 1'b0;
    push_addr   = '0;
    flush       = 1'b0;

    if (start) begin
      // A new start edge wins over everything, including a pending byte.
      state_d = S_HEADER;
      cnt_d   = '0;
      tail_d  = 1'b0;
      flush   = 1'b1;
    end else if (active && stop) begin
      state_d = S_ERROR;
      flush   = 1'b1;
    end else if (cap) begin
      case (state_q)
        S_HEADER: begin
          cnt_d = cnt_inc;
          if (cnt_q < 22'd4 && byte_q != magic_byte(cnt_q[1:0])) begin
            state_d = S_ERROR;
            flush   = 1'b1;
          end else begin
            case (cnt_q[3:0])
              4'd4: prg_size_d = byte_q;
              4'd5: chr_size_d = byte_q;
              4'd6: begin
                mapper_d[3:0] = byte_q[7:4];
                trainer_d     = byte_q[2];
                mirroring_d   = byte_q[0];
              end
              4'd7: mapper_d[7:4] = byte_q[7:4];
              4'd15: begin
                cnt_d = '0;
                if (trainer_q) begin
                  state_d = S_TRAINER;
                end else if (prg_size_q != 8'd0) begin
                  state_d = S_PRG;
                end else begin
                  state_d = S_ERROR;
                  flush   = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_TRAINER: begin
          cnt_d = cnt_inc;
          if (cnt_q == 22'd511) begin
            cnt_d = '0;
            // An image with a trainer but no PRG has nothing to load.
            if (prg_size_q != 8'd0) begin
              state_d = S_PRG;
            end else begin
              state_d = S_ERROR;
              flush   = 1'b1;
            end
          end
        end
        S_PRG, S_CHR: begin
          if (fifo_full && !pop) begin
            // No room and nothing leaving this cycle: the byte is lost.
            state_d = S_ERROR;
            flush   = 1'b1;
          end else begin
            push      = 1'b1;
            push_addr = sec_base + cnt_q;   // wraps modulo 2^22
            cnt_d     = cnt_inc;
            if (cnt_inc == sec_len) begin
              cnt_d = '0;
              if (state_q == S_PRG && chr_size_q != 8'd0) begin
                state_d = S_CHR;
              end else begin
                tail_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end else if (tail_q && fifo_empty) begin
      // Last byte queued and last ack received.
      state_d = S_DONE;
      tail_d  = 1'b0;
    end
  end

  // FIFO pointer/occupancy update; push and pop in one cycle cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Sequential state
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tail_q      <= 1'b0;
      prg_size_q  <= '0;
      chr_size_q  <= '0;
      mapper_q    <= '0;
      trainer_q   <= 1'b0;
      mirroring_q <= 1'b0;
      loading_q   <= 1'b0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      prg_size_q  <= prg_size_d;
      chr_size_q  <= chr_size_d;
      mapper_q    <= mapper_d;
      trainer_q   <= trainer_d;
      mirroring_q <= mirroring_d;
      loading_q   <= rom_loading;
      valid_q     <= rom_do_valid;
      stb_q       <= valid_rise;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Datapath storage; only read behind valid control state, so no reset.
  always_ff @(posedge clk) begin
    if (valid_rise) byte_q <= rom_do;
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= push_addr;
      fifo_data_q[wr_ptr_q] <= byte_q;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Gating with the (async-reset) occupancy forces the bus to zero in reset.
  assign mem_we       = ~fifo_empty;
  assign mem_addr     = fifo_empty ? 22'd0 : fifo_addr_q[rd_ptr_q];
  assign mem_din      = fifo_empty ? 8'd0  : fifo_data_q[rd_ptr_q];
  assign prg_size     = prg_size_q;
  assign chr_size     = chr_size_q;
  assign mapper       = mapper_q;
  assign mirroring    = mirroring_q;
  assign busy         = active | ~fifo_empty;
  assign loader_done  = (state_q == S_DONE);
  assign loader_error = (state_q == S_ERROR);

endmodule
